// File: rtl/pll_ssc_gen.sv
// pll_ssc_gen: spread-spectrum modulator that ramps a fractional-N divide ratio {ratio, fraction}
// Ports: clk_i, rst_i (sync, active-high); ssc_en_i, ratio_i, fraction_i, frac_step_i,
// cyc_to_peak_m1_i, center_i configure the sweep; tick_i paces it; ratio_o/fraction_o with
// upd_valid_o/upd_ready_i carry updates to the PLL; ovr_o pulses when an unaccepted update is
// overwritten; active_o is high outside IDLE.
// Build option: PLL_SSC_CENTER_SPREAD_EN enables center-spread (adds FALL_B and a counter bit).
module pll_ssc_gen #(
  parameter int RATIO_W = 10,
  parameter int FRAC_W  = 24,
  parameter int CNT_W   = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ssc_en_i,
  input  logic [RATIO_W-1:0] ratio_i,
  input  logic [FRAC_W-1:0]  fraction_i,
  input  logic [FRAC_W-1:0]  frac_step_i,
  input  logic [CNT_W-1:0]   cyc_to_peak_m1_i,
  input  logic               center_i,
  input  logic               tick_i,
  input  logic               upd_ready_i,
  output logic               upd_valid_o,
  output logic [RATIO_W-1:0] ratio_o,
  output logic [FRAC_W-1:0]  fraction_o,
  output logic               ovr_o,
  output logic               active_o
);
  localparam int W = RATIO_W + FRAC_W;
`ifdef PLL_SSC_CENTER_SPREAD_EN
  localparam int CW = CNT_W + 1;
  typedef enum logic [2:0] {IDLE, FALL_A, RISE, FALL_B, RETURN} state_e;
  logic center_q, center_d;
`else
  localparam int CW = CNT_W;
  typedef enum logic [2:0] {IDLE, FALL_A, RISE, RETURN} state_e;
  logic unused_center;
  assign unused_center = center_i;
`endif
  state_e state_q, state_d, after_rise;
  logic signed [W:0] off_q, off_d, off_up, off_dn, step_x;
  logic [W:0] mag;
  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic [W-1:0] n_q, n_d, n_sel, out_q, out_d;
  logic [FRAC_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic signed [W+1:0] sum;
  logic last, load, ret_done, valid_q, ovr_q;
  always_comb begin
    step_x = $signed({{(W+1-FRAC_W){1'b0}}, step_q});
    off_up = off_q + step_x;
    off_dn = off_q - step_x;
    mag = off_q[W] ? -off_q : off_q;
    ret_done = mag <= step_x;
`ifdef PLL_SSC_CENTER_SPREAD_EN
    after_rise = center_q ? FALL_B : FALL_A;
    // center-spread rises for 2K ticks: last count is 2K-1 = {K-1, 1}
    lim = (state_q == RISE && center_q) ? {k_q, 1'b1} : {1'b0, k_q};
`else
    after_rise = FALL_A;
    lim = k_q;
`endif
    last = cnt_q == lim;
    load = 1'b0;
    state_d = state_q;
    off_d = off_q;
    if (tick_i)
      case (state_q)
        IDLE: begin
          off_d = '0;
          load = ssc_en_i;
          state_d = ssc_en_i ? FALL_A : IDLE;
        end
        FALL_A: begin
          off_d = ssc_en_i ? off_dn : off_q;
          state_d = !ssc_en_i ? RETURN : last ? RISE : FALL_A;
        end
        RISE: begin
          off_d = ssc_en_i ? off_up : off_q;
          state_d = !ssc_en_i ? RETURN : last ? after_rise : RISE;
          load = ssc_en_i && last && after_rise == FALL_A;
        end
`ifdef PLL_SSC_CENTER_SPREAD_EN
        FALL_B: begin
          // the final FALL_B step lands on OFF=0, so dropping enable there goes straight to IDLE
          off_d = (ssc_en_i || last) ? off_dn : off_q;
          state_d = last ? (ssc_en_i ? FALL_A : IDLE) : ssc_en_i ? FALL_B : RETURN;
          load = ssc_en_i && last;
        end
`endif
        RETURN: begin
          off_d = ret_done ? '0 : off_q[W] ? off_up : off_dn;
          state_d = ret_done ? IDLE : RETURN;
        end
        default: state_d = IDLE;
      endcase
    cnt_d = !tick_i ? cnt_q : (state_d != state_q) ? '0 : cnt_q + CW'(1);
    n_d = load ? {ratio_i, fraction_i} : n_q;
    step_d = load ? frac_step_i : step_q;
    k_d = load ? cyc_to_peak_m1_i : k_q;
`ifdef PLL_SSC_CENTER_SPREAD_EN
    center_d = load ? center_i : center_q;
`endif
    // IDLE follows the live nominal ratio; ramps use the shadowed one
    n_sel = state_q == IDLE ? {ratio_i, fraction_i} : n_q;
    sum = $signed({2'b00, n_sel}) + $signed({off_d[W], off_d});
    out_d = !tick_i ? out_q : sum[W+1] ? '0 : sum[W] ? '1 : sum[W-1:0];
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      off_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      step_q <= '0;
      k_q <= '0;
`ifdef PLL_SSC_CENTER_SPREAD_EN
      center_q <= 1'b0;
`endif
      out_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q <= off_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      step_q <= step_d;
      k_q <= k_d;
`ifdef PLL_SSC_CENTER_SPREAD_EN
      center_q <= center_d;
`endif
      out_q <= out_d;
      valid_q <= tick_i || (valid_q && !upd_ready_i);
      ovr_q <= tick_i && valid_q && !upd_ready_i;
    end
  assign ratio_o = out_q[W-1:FRAC_W];
  assign fraction_o = out_q[FRAC_W-1:0];
  assign upd_valid_o = valid_q;
  assign ovr_o = ovr_q;
  assign active_o = state_q != IDLE;
endmodule

// File: doc/pll_ssc_gen.md
PLL_SSC_GEN -- requirements
Module: pll_ssc_gen

Interface
REQ-001 SHALL have parameter RATIO_W, default 10: integer divide-ratio width.
REQ-002 SHALL have parameter FRAC_W, default 24: fractional width; STEP_W equals FRAC_W.
REQ-003 SHALL have parameter CNT_W, default 9: width of the cycles-to-peak field.
REQ-004 SHALL have port clk_i, input, 1: the single clock.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port ssc_en_i, input, 1: spread-spectrum enable.
REQ-007 SHALL have port ratio_i, input, RATIO_W: nominal integer ratio.
REQ-008 SHALL have port fraction_i, input, FRAC_W: nominal fraction.
REQ-009 SHALL have port frac_step_i, input, FRAC_W: offset step per tick (unsigned).
REQ-010 SHALL have port cyc_to_peak_m1_i, input, CNT_W: ramp length K minus 1.
REQ-011 SHALL have port center_i, input, 1: 0 = down-spread, 1 = center-spread.
REQ-012 SHALL have port tick_i, input, 1: modulation update strobe, already synchronous to clk_i.
REQ-013 SHALL have port upd_ready_i, input, 1: PLL interface accepts the update.
REQ-014 SHALL have port upd_valid_o, output, 1: an update is pending.
REQ-015 SHALL have port ratio_o, output, RATIO_W: modulated integer ratio.
REQ-016 SHALL have port fraction_o, output, FRAC_W: modulated fraction.
REQ-017 SHALL have port ovr_o, output, 1: one-cycle pulse when an unaccepted update is overwritten.
REQ-018 SHALL have port active_o, output, 1: FSM is not in IDLE.

Function
REQ-019 SHALL define N = {ratio, fraction} (W = RATIO_W+FRAC_W bits) and keep a signed offset OFF of W+1 bits; output = N + OFF, clamped to [0, 2^W-1].
REQ-020 SHALL use FSM states IDLE, FALL_A, RISE, FALL_B, RETURN; all transitions and offset updates SHALL occur only on cycles with tick_i=1.
REQ-021 SHALL, in IDLE, hold OFF=0 and publish N on each tick.
REQ-022 SHALL, in IDLE with ssc_en_i=1 on a tick, latch ratio, fraction, step, K and center into shadow registers, then enter FALL_A.
REQ-023 SHALL, in FALL_A, apply OFF -= step each tick; after K ticks it SHALL enter RISE.
REQ-024 SHALL, in RISE, apply OFF += step each tick for K ticks (down-spread) or 2K ticks (center-spread); it SHALL then enter FALL_A (down-spread) or FALL_B (center-spread).
REQ-025 SHALL, in FALL_B, apply OFF -= step for K ticks, then enter FALL_A if ssc_en_i=1, else IDLE; shadow registers SHALL be reloaded only at period boundaries.
REQ-026 SHALL use a ramp tick counter of CNT_W+1 bits, cleared on every state change.
REQ-027 SHALL enter RETURN on a tick where ssc_en_i=0 outside IDLE; in RETURN it SHALL move OFF toward 0 by step per tick, clamp at exactly 0, then enter IDLE.
REQ-028 SHALL, with step=0, run the FSM with constant output N.
REQ-029 SHALL register the output; on each tick it SHALL load the new value and set upd_valid_o the next cycle; upd_valid_o SHALL clear on the cycle after upd_valid_o and upd_ready_i are both 1.
REQ-030 SHALL, on a tick while upd_valid_o=1 and upd_ready_i=0, overwrite the value, hold upd_valid_o, and pulse ovr_o; when tick and acceptance coincide, it SHALL present the new value with valid still set, without ovr_o.

Reset
REQ-031 SHALL, under rst_i=1, set state=IDLE, OFF=0, counter=0, shadows=0, ratio_o=0, fraction_o=0, upd_valid_o=0, ovr_o=0, active_o=0.
REQ-032 SHALL, on reset mid-ramp, abandon the ramp without a RETURN phase, dropping any pending update.

Configuration
REQ-033 SHALL support macro PLL_SSC_CENTER_SPREAD_EN; when defined, center_i SHALL select center-spread and the FALL_B state SHALL exist.
REQ-034 SHALL, when PLL_SSC_CENTER_SPREAD_EN is undefined, ignore center_i, force down-spread, and omit FALL_B and the extra counter bit.

Verification
REQ-035 SHALL cover down-spread: ratio=100, fraction=0, step=0x000100, K=4 (cyc=3), ready=1, ticks every 4 cycles -> outputs follow 100.0, then minimum {99, 0xFFFC00} after 4 ticks, then back to {100, 0} after 8 ticks, repeating.
REQ-036 SHALL cover center-spread with the same values -> minimum {99, 0xFFFC00}, maximum {100, 0x000400}, period 16 ticks.
REQ-037 SHALL cover deassertion: ssc_en_i dropped when OFF=-0x300 -> RETURN for 3 ticks, output {100, 0}, then IDLE with active_o=0.
REQ-038 SHALL cover backpressure: upd_ready_i=0 across two ticks -> one ovr_o pulse, upd_valid_o held, latest value presented.
REQ-039 SHALL cover clamping: ratio=0, fraction=0x000200, step=0x000100, K=4 -> output clamps at 0 and never wraps.
REQ-040 SHALL cover reset: rst_i mid-RISE -> all outputs zero the next cycle, state=IDLE.
